lsu_mem_port: RTL and testbench

Parametrised load/store unit sitting between the multicycle datapath and data memory. It generalises the datapath's fixed word/LDRB path to byte, halfword, word and (64-bit builds) doubleword accesses, with byte-lane enables on stores, lane extraction and extension on loads, and misalignment detection. It runs a valid/ready request handshake towards the datapath and a decoupled request/response handshake towards memory, which tolerates any memory latency.

---
 rtl/lsu_mem_port.sv | 172 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit: sizes byte..dword, lane enables/replication on stores, lane extraction on loads.
// Optional LSU_SIGNED_LOAD_EN builds sign extension of loads; otherwise loads always zero-extend.
module lsu_mem_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              bad_size, misaligned, accept_err;
    logic [LB-1:0]     off;
    logic [NB-1:0]     be_base;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] shifted, size_mask, load_data;

    assign bad_size   = (req_size == 2'b11) && (DATA_W != 64);
    assign accept_err = bad_size || misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req_valid) state_next = accept_err ? RESP : REQ;
            REQ:  if (mem_ready) state_next = we_reg ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef LSU_SIGNED_LOAD_EN
    logic signed_reg;
    logic sign_bit;
`else
    logic unused_signed;
    assign unused_signed = req_signed;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
`ifdef LSU_SIGNED_LOAD_EN
            signed_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                we_reg    <= req_we;
                size_reg  <= req_size;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                rdata_reg <= '0;
                err_reg   <= accept_err;
`ifdef LSU_SIGNED_LOAD_EN
                signed_reg <= req_signed;
`endif
            end
            if (state_reg == WAIT && mem_rvalid) begin
                rdata_reg <= load_data;
            end
        end
    end

    assign off = addr_reg[LB-1:0];

    always_comb begin
        be_base = '1;
        case (size_reg)
            2'b00:   be_base = NB'(1);
            2'b01:   be_base = NB'(3);
            2'b10:   be_base = NB'(15);
            default: be_base = '1;
        endcase
    end

    // Each lane takes the byte of the access that lands on it when the datum is repeated.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane;
        assign lane = (size_reg == 2'b00) ? wdata_reg[7:0] :
                      (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                      (size_reg == 2'b10) ? wdata_reg[8*(gi%4) +: 8] :
                                            wdata_reg[8*gi +: 8];
        assign wdata_rep[8*gi +: 8] = lane;
    end

    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        size_mask = '1;
        case (size_reg)
            2'b00:   size_mask = DATA_W'(8'hFF);
            2'b01:   size_mask = DATA_W'(16'hFFFF);
            2'b10:   size_mask = DATA_W'(32'hFFFF_FFFF);
            default: size_mask = '1;
        endcase
    end

`ifdef LSU_SIGNED_LOAD_EN
    always_comb begin
        sign_bit = shifted[DATA_W-1];
        case (size_reg)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
    end
    assign load_data = (shifted & size_mask) | ((signed_reg && sign_bit) ? ~size_mask : '0);
`else
    assign load_data = shifted & size_mask;
`endif

    // Memory side is driven only while a request is outstanding, so it idles at zero.
    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign mem_valid = (state_reg == REQ);
    assign mem_we    = mem_valid && we_reg;
    assign mem_addr  = mem_valid ? {addr_reg[ADDR_W-1:LB], LB'(0)} : '0;
    assign mem_be    = mem_valid ? (be_base << off) : '0;
    assign mem_wdata = mem_valid ? wdata_rep : '0;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rsp_valid ? rdata_reg : '0;
    assign rsp_err   = rsp_valid && err_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit instance for most cases and a 64-bit one for dword access.
module tb_lsu_mem_port;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        d_req_valid, d_req_ready, d_req_we, d_req_signed;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_rsp_valid, d_rsp_err, d_busy;
    logic [63:0] d_rsp_rdata;
    logic        d_mem_valid, d_mem_ready, d_mem_we, d_mem_rvalid;
    logic [31:0] d_mem_addr;
    logic [63:0] d_mem_wdata, d_mem_rdata;
    logic [7:0]  d_mem_be;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LSU_SIGNED_LOAD_EN
    localparam logic [31:0] EXP_SB = 32'hFFFF_FF80;
    localparam logic [31:0] EXP_SH = 32'hFFFF_8001;
`else
    localparam logic [31:0] EXP_SB = 32'h0000_0080;
    localparam logic [31:0] EXP_SH = 32'h0000_8001;
`endif

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(32), .DATA_W(32)) u32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_port #(.ADDR_W(32), .DATA_W(64)) u64 (
        .clk(clk), .reset(reset),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
        .req_size(d_req_size), .req_signed(d_req_signed), .req_addr(d_req_addr),
        .req_wdata(d_req_wdata), .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata),
        .rsp_err(d_rsp_err), .busy(d_busy), .mem_valid(d_mem_valid), .mem_ready(d_mem_ready),
        .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_be(d_mem_be), .mem_wdata(d_mem_wdata),
        .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle; returns one cycle after acceptance.
    task automatic issue32(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic issue64(input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [63:0] wd);
        d_req_we = we; d_req_size = sz; d_req_signed = 1'b0; d_req_addr = a; d_req_wdata = wd;
        d_req_valid = 1'b1;
        tick();
        d_req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = 0;
        d_req_valid = 0; d_req_we = 0; d_req_size = 0; d_req_signed = 0; d_req_addr = 0;
        d_req_wdata = 0; d_mem_ready = 1; d_mem_rvalid = 0; d_mem_rdata = 0;
        tick(); tick();
        reset = 1'b0;

        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);

        // Half store at 0x202
        issue32(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234);
        check("hs_mem_valid", mem_valid, 1);
        check("hs_mem_we", mem_we, 1);
        check("hs_mem_addr", mem_addr, 32'h200);
        check("hs_mem_be", mem_be, 4'b1100);
        check("hs_mem_wdata", mem_wdata, 32'h1234_1234);
        check("hs_req_ready", req_ready, 0);
        tick();
        check("hs_rsp_valid", rsp_valid, 1);
        check("hs_rsp_rdata", rsp_rdata, 0);
        check("hs_rsp_err", rsp_err, 0);
        tick();
        check("hs_rsp_done", rsp_valid, 0);
        check("hs_idle_ready", req_ready, 1);

        // Signed byte load at 0x103
        issue32(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        check("sb_mem_addr", mem_addr, 32'h100);
        check("sb_mem_be", mem_be, 4'b1000);
        check("sb_mem_we", mem_we, 0);
        tick();
        check("sb_wait_rsp", rsp_valid, 0);
        mem_rvalid = 1; mem_rdata = 32'h80AA_BBCC;
        tick();
        mem_rvalid = 0;
        check("sb_rsp_valid", rsp_valid, 1);
        check("sb_rsp_rdata", rsp_rdata, EXP_SB);
        tick();

        // Signed half load at 0x2
        issue32(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        check("sh_mem_be", mem_be, 4'b1100);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h8001_7F7F;
        tick();
        mem_rvalid = 0;
        check("sh_rsp_rdata", rsp_rdata, EXP_SH);
        tick();

        // Misaligned half at 0x101
        issue32(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
        check("mis_rsp_valid", rsp_valid, 1);
        check("mis_rsp_err", rsp_err, 1);
        check("mis_mem_valid", mem_valid, 0);
        tick();
        check("mis_done", rsp_valid, 0);

        // Dword on a 32-bit bus is illegal
        issue32(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
        check("dw32_rsp_err", rsp_err, 1);
        check("dw32_mem_valid", mem_valid, 0);
        tick();

        // Backpressure: word load at 0x40, ready low 5 cycles, stray rvalid meanwhile
        mem_ready = 0;
        issue32(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_mem_valid_%0d", i), mem_valid, 1);
            check($sformatf("bp_mem_addr_%0d", i), mem_addr, 32'h40);
            check($sformatf("bp_busy_%0d", i), {req_ready, busy}, 2'b01);
            tick();
        end
        mem_rvalid = 0;
        mem_ready = 1;
        check("bp_still_valid", mem_valid, 1);
        tick();
        check("bp_no_early_rsp", rsp_valid, 0);
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 0;
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // Reset while waiting for read data
        issue32(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        tick();
        check("rm_in_wait", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rm_ready", req_ready, 1);
        check("rm_rsp_valid", rsp_valid, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h5555_5555;
        tick();
        mem_rvalid = 0;
        check("rm_stale_rsp", rsp_valid, 0);
        check("rm_stale_busy", busy, 0);
        tick();
        check("rm_stale_rsp2", rsp_valid, 0);

        // 64-bit instance: dword load at 0x08
        issue64(1'b0, 2'b11, 32'h8, 64'h0);
        check("dw_mem_be", d_mem_be, 8'hFF);
        check("dw_mem_addr", d_mem_addr, 32'h8);
        tick();
        d_mem_rvalid = 1; d_mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        d_mem_rvalid = 0;
        check("dw_rsp_valid", d_rsp_valid, 1);
        check("dw_rsp_err", d_rsp_err, 0);
        check("dw_rsp_rdata", d_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        tick();

        // 64-bit byte store at 0x0D
        issue64(1'b1, 2'b00, 32'hD, 64'h0000_0000_0000_00A5);
        check("b64_mem_addr", d_mem_addr, 32'h8);
        check("b64_mem_be", d_mem_be, 8'b0010_0000);
        check("b64_mem_wdata", d_mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        check("b64_rsp_valid", d_rsp_valid, 1);
        tick();

        // 64-bit word load at offset 4
        issue64(1'b0, 2'b10, 32'h24, 64'h0);
        check("w64_mem_be", d_mem_be, 8'hF0);
        tick();
        d_mem_rvalid = 1; d_mem_rdata = 64'hCAFE_F00D_1234_5678;
        tick();
        d_mem_rvalid = 0;
        check("w64_rsp_rdata", d_rsp_rdata, 64'h0000_0000_CAFE_F00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
